program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader sitting directly upstream of the CPU core. Receives the program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them into instruction memory from word address 0 upward, and holds the CPU in reset with enable deasserted until an end-of-image marker arrives. After a fixed boot delay it releases the CPU's reset and raises its enable. It then stays in the run state until its own reset.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width (capacity 2^ADDR_WIDTH words)
- END_WORD, 32'hFFFF_FFFF, end-of-image marker word; never written to memory
- BOOT_DELAY, 4, cycles the CPU reset is held after the marker; legal range ≥1

Ports:
- CLOCK  in  1  clock; all state updates on rising edge
- RESET  in  1  reset, synchronous, active-high
- BYTE_VALID  in  1  BYTE_DATA carries a valid byte
- BYTE_DATA  in  8  image byte; first byte of each word is bits [31:24]
- BYTE_READY  out  1  loader accepts a byte this cycle
- IM_WRITE_EN  out  1  instruction memory write strobe
- IM_WRITE_ADDR  out  ADDR_WIDTH  word address of the write
- IM_WRITE_DATA  out  32  word to write
- CPU_RESET  out  1  drives the CPU's RESET
- CPU_ENABLE  out  1  drives the CPU's ENABLE
- LOAD_DONE  out  1  image loaded and CPU running
- OVERFLOW  out  1  image exceeded memory capacity; sticky until RESET
- WORD_COUNT  out  ADDR_WIDTH+1  words written so far

## Operation
- FSM states: LOAD, WRITE, BOOT, RUN, ERROR. All outputs are decoded from registered state (Moore).
- A byte transfer occurs when BYTE_VALID && BYTE_READY. BYTE_READY = 1 only in LOAD.
- LOAD:
  - A 2-bit byte index counts 0..3.
  - Each transfer shifts the byte into a 24-bit shift register and increments the index.
  - On the transfer with index==3, the assembled word is {shift[23:0], BYTE_DATA}. The index wraps to 0.
    - Word == END_WORD: go to BOOT. The marker is not written and the count is unchanged.
    - Otherwise, if WORD_COUNT == 2^ADDR_WIDTH: go to ERROR.
    - Otherwise: latch the word into the data register and go to WRITE.
- WRITE (exactly one cycle):
  - IM_WRITE_EN = 1, IM_WRITE_ADDR = WORD_COUNT[ADDR_WIDTH-1:0], IM_WRITE_DATA = latched word.
  - WORD_COUNT increments at the end of the cycle. Return to LOAD.
- BOOT:
  - The delay counter clears on entry and increments each cycle.
  - When counter == BOOT_DELAY-1, go to RUN.
- RUN: terminal. CPU_RESET = 0, CPU_ENABLE = 1, LOAD_DONE = 1.
- ERROR: terminal. OVERFLOW = 1, CPU_RESET = 1, CPU_ENABLE = 0.
- CPU_RESET = 1 and CPU_ENABLE = 0 in LOAD, WRITE, BOOT and ERROR.
- IM_WRITE_EN = 0 in every state except WRITE.
- IM_WRITE_ADDR and IM_WRITE_DATA are don't-care when IM_WRITE_EN = 0. They are driven 0 in the reference implementation.
- Bytes presented while BYTE_READY = 0 are not consumed. The source must hold them (standard valid/ready).

## Timing
- Reset values: state LOAD, BYTE_READY 1, IM_WRITE_EN 0, IM_WRITE_ADDR 0, IM_WRITE_DATA 0, CPU_RESET 1, CPU_ENABLE 0, LOAD_DONE 0, OVERFLOW 0, WORD_COUNT 0, byte index 0, shift register 0.
- RESET asserted in any state: next cycle matches the reset values. Partially assembled bytes are discarded and the CPU is re-held in reset.
- Latency, 4th byte accepted at edge t:
  - Data word: IM_WRITE_EN high in cycle t+1, BYTE_READY low in cycle t+1, BYTE_READY high again in t+2.
  - Marker: BOOT occupies cycles t+1 … t+BOOT_DELAY. CPU_RESET falls and CPU_ENABLE rises at cycle t+1+BOOT_DELAY.
- Maximum throughput: 4 bytes per 5 cycles.
- WORD_COUNT shows the new value in the cycle after WRITE.
- Capacity boundary:
  - Exactly 2^ADDR_WIDTH data words followed by the marker is legal; the last write goes to address 2^ADDR_WIDTH−1.
  - A further non-marker word causes ERROR instead.
- Marker as the very first word: BOOT with WORD_COUNT = 0 (empty image is legal).
- BYTE_VALID gaps between bytes of a word are allowed; the index holds its value.

## Test plan
- Reset then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF, BOOT_DELAY = 4 -> writes 0x20080005 @0 and 0x00000000 @1. WORD_COUNT = 2. CPU_ENABLE rises exactly 5 cycles after the last FF is accepted. LOAD_DONE = 1.
- Same stream with BYTE_VALID held high continuously -> BYTE_READY low exactly in each WRITE cycle. No byte lost or duplicated. Data matches.
- ADDR_WIDTH = 2: 4 words 0x11111111..0x44444444 then marker -> addresses 0..3 written, RUN. Repeat with a 5th data word -> OVERFLOW = 1, CPU_RESET stays 1, no 5th write.
- Marker only -> no IM_WRITE_EN pulse, WORD_COUNT = 0, RUN after BOOT_DELAY.
- RESET asserted after 2 bytes of word 1, then a full image -> first word assembled from post-reset bytes only. Writes start at address 0.
- RESET asserted in RUN -> next cycle CPU_RESET = 1, CPU_ENABLE = 0, LOAD_DONE = 0, WORD_COUNT = 0, BYTE_READY = 1.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if
//   Groups the byte-stream handshake, the instruction-memory write port and
//   the CPU control/status lines of the boot loader.
//   master : image source / supervisor side (drives bytes, observes status)
//   slave  : loader side (accepts bytes, drives memory and CPU control)
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  BYTE_VALID;
  logic [7:0]            BYTE_DATA;
  logic                  BYTE_READY;
  logic                  IM_WRITE_EN;
  logic [ADDR_WIDTH-1:0] IM_WRITE_ADDR;
  logic [31:0]           IM_WRITE_DATA;
  logic                  CPU_RESET;
  logic                  CPU_ENABLE;
  logic                  LOAD_DONE;
  logic                  OVERFLOW;
  logic [ADDR_WIDTH:0]   WORD_COUNT;

  modport master (
    output BYTE_VALID, BYTE_DATA,
    input  BYTE_READY, IM_WRITE_EN, IM_WRITE_ADDR, IM_WRITE_DATA,
    input  CPU_RESET, CPU_ENABLE, LOAD_DONE, OVERFLOW, WORD_COUNT
  );

  modport slave (
    input  BYTE_VALID, BYTE_DATA,
    output BYTE_READY, IM_WRITE_EN, IM_WRITE_ADDR, IM_WRITE_DATA,
    output CPU_RESET, CPU_ENABLE, LOAD_DONE, OVERFLOW, WORD_COUNT
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader in front of the CPU core. Assembles big-endian 32-bit
//   words from a valid/ready byte stream, writes them to instruction memory
//   from word 0 upward, and keeps the CPU in reset until the end-of-image
//   marker has been seen and BOOT_DELAY cycles have elapsed.
// Ports
//   CLOCK : clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : program_loader_if.slave
//           BYTE_VALID/BYTE_DATA/BYTE_READY     byte stream in
//           IM_WRITE_EN/IM_WRITE_ADDR/DATA      instruction memory write
//           CPU_RESET/CPU_ENABLE                CPU control
//           LOAD_DONE/OVERFLOW/WORD_COUNT       status
//
// state | meaning
// LOAD  | accepting bytes, assembling the next word
// WRITE | one-cycle memory write of the latched word
// BOOT  | marker seen, holding CPU reset for BOOT_DELAY cycles
// RUN   | CPU released and enabled (terminal)
// ERROR | image larger than memory, CPU held (terminal)
module program_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF,
  parameter int          BOOT_DELAY = 4
) (
  input logic             CLOCK,
  input logic             RESET,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    WRITE = 3'd1,
    BOOT  = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CNT_W-1:0]    BOOT_LAST = CNT_W'(BOOT_DELAY - 1);
  // WORD_COUNT is one bit wider than the address so a full memory is visible
  localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q;
  logic [23:0]         shift_q;
  logic [31:0]         data_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [CNT_W-1:0]    boot_cnt_q;

  logic        take;
  logic        last_byte;
  logic [31:0] word_in;

  assign take      = bus.BYTE_VALID && (state_q == LOAD);
  assign last_byte = take && (byte_idx_q == 2'd3);
  assign word_in   = {shift_q, bus.BYTE_DATA};

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.BYTE_READY    = 1'b0;
    bus.IM_WRITE_EN   = 1'b0;
    bus.IM_WRITE_ADDR = '0;
    bus.IM_WRITE_DATA = '0;
    bus.CPU_RESET     = 1'b1;
    bus.CPU_ENABLE    = 1'b0;
    bus.LOAD_DONE     = 1'b0;
    bus.OVERFLOW      = 1'b0;
    case (state_q)
      LOAD: begin
        bus.BYTE_READY = 1'b1;
        if (last_byte) begin
          if (word_in == END_WORD)      state_d = BOOT;
          else if (count_q == CAPACITY) state_d = ERROR;
          else                          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.IM_WRITE_EN   = 1'b1;
        bus.IM_WRITE_ADDR = count_q[ADDR_WIDTH-1:0];
        bus.IM_WRITE_DATA = data_q;
        state_d           = LOAD;
      end
      BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        bus.CPU_RESET  = 1'b0;
        bus.CPU_ENABLE = 1'b1;
        bus.LOAD_DONE  = 1'b1;
      end
      ERROR: begin
        bus.OVERFLOW = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  assign bus.WORD_COUNT = count_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      count_q    <= '0;
      boot_cnt_q <= '0;
    end else begin
      if (take) begin
        shift_q    <= word_in[23:0];
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (last_byte && (state_d == WRITE)) data_q <= word_in;
      if (state_q == WRITE) count_q <= count_q + (ADDR_WIDTH+1)'(1);
      // Held at zero outside BOOT, so it is already clear on entry
      if (state_q == BOOT) boot_cnt_q <= boot_cnt_q + CNT_W'(1);
      else                 boot_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int AW  = 2;
  localparam int BD  = 4;
  localparam int CAP = 1 << AW;
  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .END_WORD(END_W), .BOOT_DELAY(BD)) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected writes: {address, data}
  logic [63:0] exp_q[$];

  logic [31:0] img [0:7];
  int          img_len;
  bit          gaps;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.IM_WRITE_EN === 1'b1) begin
      chk("ready_low_in_write", 64'(bus.BYTE_READY), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 bus.IM_WRITE_ADDR, bus.IM_WRITE_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(bus.IM_WRITE_ADDR), 64'(e[63:32]));
        chk("write_data", 64'(bus.IM_WRITE_DATA), 64'(e[31:0]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.BYTE_VALID = 1'b0;
    bus.BYTE_DATA  = 8'h00;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_byte_ready", 64'(bus.BYTE_READY), 64'd1);
    chk("rst_we",         64'(bus.IM_WRITE_EN), 64'd0);
    chk("rst_cpu_reset",  64'(bus.CPU_RESET), 64'd1);
    chk("rst_cpu_enable", 64'(bus.CPU_ENABLE), 64'd0);
    chk("rst_load_done",  64'(bus.LOAD_DONE), 64'd0);
    chk("rst_overflow",   64'(bus.OVERFLOW), 64'd0);
    chk("rst_word_count", 64'(bus.WORD_COUNT), 64'd0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  gap;
    bit  r;
    bit  ok;
    gap = gaps ? int'($urandom_range(0, 3)) : 0;
    if (gap > 0) begin
      bus.BYTE_VALID = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.BYTE_VALID = 1'b1;
    bus.BYTE_DATA  = b;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = bus.BYTE_READY;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] s;
    for (int b = 0; b < 4; b++) begin
      s = w >> (24 - 8 * b);
      send_byte(s[7:0]);
    end
  endtask

  task automatic check_boot(input int n);
    bus.BYTE_VALID = 1'b0;
    for (int k = 1; k <= BD; k++) begin
      @(negedge clk);
      chk("boot_cpu_enable", 64'(bus.CPU_ENABLE), 64'd0);
      chk("boot_cpu_reset",  64'(bus.CPU_RESET), 64'd1);
    end
    @(negedge clk);
    chk("run_cpu_enable", 64'(bus.CPU_ENABLE), 64'd1);
    chk("run_cpu_reset",  64'(bus.CPU_RESET), 64'd0);
    chk("run_load_done",  64'(bus.LOAD_DONE), 64'd1);
    chk("run_overflow",   64'(bus.OVERFLOW), 64'd0);
    chk("run_word_count", 64'(bus.WORD_COUNT), 64'(n));
    chk("run_all_writes", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    chk("run_byte_ready", 64'(bus.BYTE_READY), 64'd0);
    chk("run_hold_enable", 64'(bus.CPU_ENABLE), 64'd1);
  endtask

  task automatic check_error(input int n);
    bus.BYTE_VALID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("err_overflow",   64'(bus.OVERFLOW), 64'd1);
      chk("err_cpu_reset",  64'(bus.CPU_RESET), 64'd1);
      chk("err_cpu_enable", 64'(bus.CPU_ENABLE), 64'd0);
      chk("err_byte_ready", 64'(bus.BYTE_READY), 64'd0);
      chk("err_load_done",  64'(bus.LOAD_DONE), 64'd0);
      chk("err_word_count", 64'(bus.WORD_COUNT), 64'(n));
    end
    chk("err_all_writes", 64'(exp_q.size()), 64'd0);
  endtask

  // Reference: words land at consecutive addresses from 0; a data word
  // arriving with memory already full ends in ERROR, else the marker boots.
  task automatic run_image();
    int cnt;
    bit err;
    cnt = 0;
    err = 1'b0;
    for (int i = 0; i < img_len; i++) begin
      send_word(img[i]);
      if (cnt == CAP) begin err = 1'b1; break; end
      exp_q.push_back({32'(cnt), img[i]});
      cnt++;
    end
    if (err) check_error(cnt);
    else begin
      send_word(END_W);
      check_boot(cnt);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == END_W) w = 32'h0;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gaps = 1'b0;
    img_len = 0;
    do_reset();

    // two words then marker, with gaps, then with continuous valid
    img[0] = 32'h2008_0005; img[1] = 32'h0000_0000; img_len = 2;
    gaps = 1'b1; run_image();
    do_reset();
    gaps = 1'b0; run_image();

    // full memory then marker
    do_reset();
    img[0] = 32'h1111_1111; img[1] = 32'h2222_2222;
    img[2] = 32'h3333_3333; img[3] = 32'h4444_4444; img_len = 4;
    run_image();

    // one word too many
    do_reset();
    img[4] = 32'h5555_5555; img_len = 5;
    run_image();

    // marker only
    do_reset();
    img_len = 0;
    run_image();

    // reset part-way through the first word
    do_reset();
    gaps = 1'b0;
    send_byte(8'hAB);
    send_byte(8'hCD);
    do_reset();
    img[0] = 32'h0102_0304; img[1] = 32'hCAFE_F00D; img_len = 2;
    run_image();
    // now in RUN; reset must drop back to load state
    do_reset();

    // randomized images, 0..5 words, random gaps
    for (int t = 0; t < 20; t++) begin
      do_reset();
      gaps = 1'($urandom_range(0, 1));
      img_len = int'($urandom_range(0, 5));
      for (int i = 0; i < img_len; i++) img[i] = rand_word();
      run_image();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
